vmem0_seq: RTL

Sequencer and arbiter for the level-1 virtual memory map RAM (2048 × 5, registered read port). It initialises every map entry to the "unmapped" value after reset, then serialises map-write requests and map-lookup requests onto the RAM's single address bus. It guarantees read-enable and write-enable are never asserted together. It sits between the map-load/lookup logic and the level-1 map RAM.

---
 rtl/vmem0_seq_if.sv | 38 +++
 rtl/vmem0_seq.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/vmem0_seq_if.sv
// vmem0_seq_if: bundles the requester handshakes and the level-1 map RAM bus
// of the vmem0_seq sequencer.
//   slave  modport : the sequencer (samples requests and ram_q, drives acks and the RAM bus)
//   master modport : the surrounding logic (requesters plus the map RAM)
// Signals: lk_req/lk_adr/lk_ack/lk_valid/lk_data    lookup handshake
//          wr_req/wr_adr/wr_data/wr_ack             map write handshake
//          ram_adr/ram_wdata/ram_rp/ram_wp/ram_q    map RAM port
//          init_busy                                initialisation sweep running
interface vmem0_seq_if #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 5
);
  logic                  lk_req;
  logic [ADDR_WIDTH-1:0] lk_adr;
  logic                  lk_ack;
  logic                  lk_valid;
  logic [DATA_WIDTH-1:0] lk_data;
  logic                  wr_req;
  logic [ADDR_WIDTH-1:0] wr_adr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_ack;
  logic [ADDR_WIDTH-1:0] ram_adr;
  logic [DATA_WIDTH-1:0] ram_wdata;
  logic                  ram_rp;
  logic                  ram_wp;
  logic [DATA_WIDTH-1:0] ram_q;
  logic                  init_busy;

  modport slave (
    input  lk_req, lk_adr, wr_req, wr_adr, wr_data, ram_q,
    output lk_ack, lk_valid, lk_data, wr_ack, ram_adr, ram_wdata, ram_rp, ram_wp, init_busy
  );

  modport master (
    output lk_req, lk_adr, wr_req, wr_adr, wr_data, ram_q,
    input  lk_ack, lk_valid, lk_data, wr_ack, ram_adr, ram_wdata, ram_rp, ram_wp, init_busy
  );
endinterface

// File: rtl/vmem0_seq.sv
// vmem0_seq: sequencer/arbiter for the level-1 virtual memory map RAM.
// After reset it sweeps every entry to INIT_VALUE, then serialises map writes
// and map lookups onto the single RAM address bus. ram_rp and ram_wp are
// never asserted together.
// Ports:
//   clk    clock
//   reset  synchronous, active-high reset (restarts the sweep at address 0)
//   bus    vmem0_seq_if.slave: lookup handshake, write handshake, RAM port, init_busy
// Configuration macro:
//   VMEM0_SEQ_RR_EN  defined   -> round-robin between write and lookup
//                    undefined -> fixed priority, write always wins
// All outputs are registered.
module vmem0_seq #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 5,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = 5'h1f
) (
  input logic        clk,
  input logic        reset,
  vmem0_seq_if.slave bus
);

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_RD,
    S_CAP,
    S_WR
  } state_t;

  state_t                state_reg;
  logic [ADDR_WIDTH-1:0] cnt_reg;
  logic                  lk_ack_reg;
  logic                  lk_valid_reg;
  logic [DATA_WIDTH-1:0] lk_data_reg;
  logic                  wr_ack_reg;
  logic [ADDR_WIDTH-1:0] ram_adr_reg;
  logic [DATA_WIDTH-1:0] ram_wdata_reg;
  logic                  ram_rp_reg;
  logic                  ram_wp_reg;
  logic                  init_busy_reg;
  logic                  grant_wr;

`ifdef VMEM0_SEQ_RR_EN
  // Set when the most recent grant went to a lookup; resets to "lookup" so
  // the first contended grant goes to the writer.
  logic last_lk_reg;
  assign grant_wr = bus.wr_req && (!bus.lk_req || last_lk_reg);
`else
  assign grant_wr = bus.wr_req;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= S_INIT;
      cnt_reg       <= '0;
      lk_ack_reg    <= 1'b0;
      lk_valid_reg  <= 1'b0;
      lk_data_reg   <= '0;
      wr_ack_reg    <= 1'b0;
      ram_adr_reg   <= '0;
      ram_wdata_reg <= '0;
      ram_rp_reg    <= 1'b0;
      ram_wp_reg    <= 1'b0;
      init_busy_reg <= 1'b1;
`ifdef VMEM0_SEQ_RR_EN
      last_lk_reg   <= 1'b1;
`endif
    end else begin
      // Strobes are single-cycle unless a state re-asserts them.
      lk_ack_reg   <= 1'b0;
      lk_valid_reg <= 1'b0;
      wr_ack_reg   <= 1'b0;
      ram_rp_reg   <= 1'b0;
      ram_wp_reg   <= 1'b0;

      case (state_reg)
        S_INIT: begin
          ram_wp_reg    <= 1'b1;
          ram_adr_reg   <= cnt_reg;
          ram_wdata_reg <= INIT_VALUE;
          cnt_reg       <= cnt_reg + 1'b1;
          // The last entry is registered here and written during the next
          // cycle; init_busy drops at the following (first IDLE) edge.
          if (cnt_reg == '1) begin
            state_reg <= S_IDLE;
          end
        end

        S_IDLE: begin
          init_busy_reg <= 1'b0;
          if (grant_wr) begin
            ram_adr_reg   <= bus.wr_adr;
            ram_wdata_reg <= bus.wr_data;
            ram_wp_reg    <= 1'b1;
            wr_ack_reg    <= 1'b1;
            state_reg     <= S_WR;
          end else if (bus.lk_req) begin
            ram_adr_reg <= bus.lk_adr;
            ram_rp_reg  <= 1'b1;
            lk_ack_reg  <= 1'b1;
            state_reg   <= S_RD;
          end
`ifdef VMEM0_SEQ_RR_EN
          if (bus.wr_req || bus.lk_req) begin
            last_lk_reg <= !grant_wr;
          end
`endif
        end

        S_WR: begin
          state_reg <= S_IDLE;
        end

        S_RD: begin
          // ram_q becomes valid during the cycle spent in CAP.
          state_reg <= S_CAP;
        end

        S_CAP: begin
          lk_data_reg  <= bus.ram_q;
          lk_valid_reg <= 1'b1;
          state_reg    <= S_IDLE;
        end

        default: begin
          state_reg <= S_INIT;
        end
      endcase
    end
  end

  assign bus.lk_ack    = lk_ack_reg;
  assign bus.lk_valid  = lk_valid_reg;
  assign bus.lk_data   = lk_data_reg;
  assign bus.wr_ack    = wr_ack_reg;
  assign bus.ram_adr   = ram_adr_reg;
  assign bus.ram_wdata = ram_wdata_reg;
  assign bus.ram_rp    = ram_rp_reg;
  assign bus.ram_wp    = ram_wp_reg;
  assign bus.init_busy = init_busy_reg;

endmodule
